// File: rtl/pattern_tx.sv
// Serial frame transmitter: sends preamble, payload and idle-'1' guard MSB first on dout.
// A start seen on the last guard edge chains the next frame with no idle gap.
module pattern_tx #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       PRE_W    = 8,
  parameter logic [PRE_W-1:0]  PREAMBLE = PRE_W'(8'b0101_0101),
  parameter int unsigned       GUARD    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_A = (DATA_W > PRE_W) ? DATA_W : PRE_W;
  localparam int unsigned MAX_N = (MAX_A > GUARD) ? MAX_A : GUARD;
  localparam int unsigned CNT_W = $clog2(MAX_N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_DATA  = 2'd2,
    S_GUARD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PRE_W-1:0]    pre_shift;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; the counter is cleared on every phase change
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // Preamble bit following the one currently on the line
    pre_shift = PREAMBLE << (cnt_q + CNT_W'(1));

    case (state_q)
      S_IDLE: begin
        dout_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_PRE;
          cnt_d   = '0;
          sr_d    = data;
          dout_d  = PREAMBLE[PRE_W-1];
          busy_d  = 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_q == CNT_W'(PRE_W - 1)) begin
          state_d = S_DATA;
          cnt_d   = '0;
          dout_d  = sr_q[DATA_W-1];
          sr_d    = sr_q << 1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          dout_d = pre_shift[PRE_W-1];
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          dout_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          dout_d = sr_q[DATA_W-1];
          sr_d   = sr_q << 1;
        end
      end
      S_GUARD: begin
        dout_d = 1'b1;
        if (cnt_q == CNT_W'(GUARD - 1)) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // Back-to-back request: next preamble directly follows the guard
          if (start) begin
            state_d = S_PRE;
            sr_d    = data;
            dout_d  = PREAMBLE[PRE_W-1];
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        dout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
